// File: rtl/hml_pkg.sv
// Shared constants and helpers for the H/M/L water-level monitor.
//   Level encodings (2-bit) and their raw HML probe codes {H,M,L}
//   FSM state encodings and fault codes
//   is_valid_hml() : thermometer-code check on a raw HML code
//   hml_to_level() : raw HML code to 2-bit level
package hml_pkg;

  localparam int unsigned HML_W = 3;
  localparam int unsigned LVL_W = 2;
  localparam int unsigned ST_W  = 2;
  localparam int unsigned FLT_W = 2;

  localparam logic [LVL_W-1:0] LVL_EMPTY = 2'd0;
  localparam logic [LVL_W-1:0] LVL_LOW   = 2'd1;
  localparam logic [LVL_W-1:0] LVL_MID   = 2'd2;
  localparam logic [LVL_W-1:0] LVL_FULL  = 2'd3;

  localparam logic [HML_W-1:0] HML_EMPTY = 3'b000;
  localparam logic [HML_W-1:0] HML_LOW   = 3'b001;
  localparam logic [HML_W-1:0] HML_MID   = 3'b011;
  localparam logic [HML_W-1:0] HML_FULL  = 3'b111;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_FILLING = 2'd1;
  localparam logic [ST_W-1:0] ST_FAULT   = 2'd2;

  localparam logic [FLT_W-1:0] FLT_NONE    = 2'b00;
  localparam logic [FLT_W-1:0] FLT_CODE    = 2'b01;
  localparam logic [FLT_W-1:0] FLT_TIMEOUT = 2'b10;

  // Only thermometer codes are physically possible with healthy probes.
  function automatic logic is_valid_hml(input logic [HML_W-1:0] code);
    return (code == HML_EMPTY) || (code == HML_LOW) ||
           (code == HML_MID)   || (code == HML_FULL);
  endfunction

  function automatic logic [LVL_W-1:0] hml_to_level(input logic [HML_W-1:0] code);
    logic [LVL_W-1:0] lvl;
    case (code)
      HML_LOW:  lvl = LVL_LOW;
      HML_MID:  lvl = LVL_MID;
      HML_FULL: lvl = LVL_FULL;
      default:  lvl = LVL_EMPTY;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/hml_debouncer.sv
// 2-FF synchroniser plus 3-bit debounce of the raw HML probe code.
//   clk, rst          : clock, async active-high reset
//   i_raw             : raw {H,M,L}
//   o_accept_c        : combinational one-cycle pulse, a code is accepted this edge
//   o_new_code_c      : code being accepted (valid while o_accept_c)
//   o_accepted_code   : last accepted code (registered)
module hml_debouncer
  import hml_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [HML_W-1:0] i_raw,
  output logic             o_accept_c,
  output logic [HML_W-1:0] o_new_code_c,
  output logic [HML_W-1:0] o_accepted_code
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [HML_W-1:0] r_sync1;
  logic [HML_W-1:0] r_sync2;
  logic [1:0]       r_sync_vld;
  logic [HML_W-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [HML_W-1:0] r_acc_code;
  logic             w_diff;
  logic             w_accept;

  // r_sync_vld marks when r_sync2 holds a real sample rather than its reset value,
  // so the first code after reset is debounced with the same latency as a change.
  assign w_diff   = (r_sync2 != r_cand);
  assign w_accept = r_sync_vld[1] &&
                    (w_diff ? (DEBOUNCE_CYCLES == 1) : (r_cnt == CNT_ACC));

  // Synchroniser, candidate/run counter, accepted code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_sync_vld <= '0;
      r_cand     <= '0;
      r_cnt      <= '0;
      r_acc_code <= '0;
    end else begin
      r_sync1    <= i_raw;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      if (r_sync_vld[1]) begin
        if (w_diff) begin
          r_cand <= r_sync2;
          r_cnt  <= CNT_W'(1);
        end else if (r_cnt != CNT_MAX) begin
          // Saturating at the threshold makes acceptance once per change.
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (w_accept) begin
        r_acc_code <= r_sync2;
      end
    end
  end

  assign o_accept_c      = w_accept;
  assign o_new_code_c    = r_sync2;
  assign o_accepted_code = r_acc_code;

endmodule

// File: rtl/hml_level_monitor.sv
// Tank level monitor: debounced HML probes, fill-valve FSM with hysteresis,
// fill timeout and latched fault.
//   clk, rst      : clock, async active-high reset
//   H, M, L       : raw level probes (1 = wet)
//   clear_fault   : single-cycle request to leave FAULT
//   level         : accepted level 0..3 (EMPTY/LOW/MID/FULL)
//   level_valid   : a valid code has been accepted since reset
//   valve_open    : fill valve command
//   irrig_allow   : irrigation permitted
//   alarm         : FAULT indication
//   fault_code    : 00 none, 01 invalid code, 10 fill timeout
module hml_level_monitor
  import hml_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FILL_TIMEOUT    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             H,
  input  logic             M,
  input  logic             L,
  input  logic             clear_fault,
  output logic [LVL_W-1:0] level,
  output logic             level_valid,
  output logic             valve_open,
  output logic             irrig_allow,
  output logic             alarm,
  output logic [FLT_W-1:0] fault_code
);

  localparam int unsigned TMO_W = $clog2(FILL_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(FILL_TIMEOUT);

  logic             w_accept_c;
  logic [HML_W-1:0] w_new_code_c;
  logic [HML_W-1:0] w_acc_code;

  logic [ST_W-1:0]  r_state;
  logic [LVL_W-1:0] r_level;
  logic             r_level_valid;
  logic [FLT_W-1:0] r_fault;
  logic [TMO_W-1:0] r_tmo;
  logic             r_valve;
  logic             r_irrig;
  logic             r_alarm;

  logic [ST_W-1:0]  w_state_n;
  logic [LVL_W-1:0] w_level_n;
  logic             w_level_valid_n;
  logic [FLT_W-1:0] w_fault_n;
  logic [TMO_W-1:0] w_tmo_n;
  logic [TMO_W-1:0] w_tmo_inc;
  logic             w_new_ok;
  logic             w_new_bad;
  logic             w_increase;
  logic             w_cur_ok;

  hml_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk             (clk),
    .rst             (rst),
    .i_raw           ({H, M, L}),
    .o_accept_c      (w_accept_c),
    .o_new_code_c    (w_new_code_c),
    .o_accepted_code (w_acc_code)
  );

  assign w_new_ok   = w_accept_c &&  is_valid_hml(w_new_code_c);
  assign w_new_bad  = w_accept_c && !is_valid_hml(w_new_code_c);
  assign w_increase = w_new_ok && (hml_to_level(w_new_code_c) > r_level);
  // Code in force this edge: a code being accepted now supersedes the stored one.
  assign w_cur_ok   = w_accept_c ? is_valid_hml(w_new_code_c) : is_valid_hml(w_acc_code);
  assign w_tmo_inc  = (r_tmo == TMO_MAX) ? r_tmo : (r_tmo + TMO_W'(1));

  // Next-state, level, fault and timeout logic
  always_comb begin
    w_state_n       = r_state;
    w_level_n       = r_level;
    w_level_valid_n = r_level_valid;
    w_fault_n       = r_fault;
    w_tmo_n         = '0;

    if (w_new_ok) begin
      w_level_n       = hml_to_level(w_new_code_c);
      w_level_valid_n = 1'b1;
    end

    if (w_new_bad) begin
      w_state_n = ST_FAULT;
      w_fault_n = FLT_CODE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Hysteresis: only an empty tank opens the valve.
          if (w_level_valid_n && (w_level_n == LVL_EMPTY)) begin
            w_state_n = ST_FILLING;
          end
        end
        ST_FILLING: begin
          if (w_level_n == LVL_FULL) begin
            w_state_n = ST_IDLE;
          end else if (!w_increase && (w_tmo_inc == TMO_MAX)) begin
            w_state_n = ST_FAULT;
            w_fault_n = FLT_TIMEOUT;
          end
        end
        ST_FAULT: begin
          if (clear_fault && w_cur_ok) begin
            w_state_n = ST_IDLE;
            w_fault_n = FLT_NONE;
          end
        end
        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
    end

    // Counter restarts on FILLING entry and on every accepted increase.
    if (w_state_n == ST_FILLING) begin
      if ((r_state == ST_FILLING) && !w_increase) begin
        w_tmo_n = w_tmo_inc;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_level       <= LVL_EMPTY;
      r_level_valid <= 1'b0;
      r_fault       <= FLT_NONE;
      r_tmo         <= '0;
      r_valve       <= 1'b0;
      r_irrig       <= 1'b0;
      r_alarm       <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_level       <= w_level_n;
      r_level_valid <= w_level_valid_n;
      r_fault       <= w_fault_n;
      r_tmo         <= w_tmo_n;
      r_valve       <= (w_state_n == ST_FILLING);
      r_alarm       <= (w_state_n == ST_FAULT);
      r_irrig       <= w_level_valid_n && (w_level_n >= LVL_LOW) && (w_state_n != ST_FAULT);
    end
  end

  assign level       = r_level;
  assign level_valid = r_level_valid;
  assign valve_open  = r_valve;
  assign irrig_allow = r_irrig;
  assign alarm       = r_alarm;
  assign fault_code  = r_fault;

endmodule
